// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers for the E stage of the MIPS core.
// A result is computed at start and committed to HI/LO after a fixed busy latency.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILOType,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILO_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 15) ? $clog2(MAXC + 1) : 4;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [3:0] HILO_MULT  = 4'd0;
  localparam logic [3:0] HILO_MULTU = 4'd1;
  localparam logic [3:0] HILO_DIV   = 4'd2;
  localparam logic [3:0] HILO_DIVU  = 4'd3;
  localparam logic [3:0] HILO_MFHI  = 4'd4;
  localparam logic [3:0] HILO_MFLO  = 4'd5;
  localparam logic [3:0] HILO_MTHI  = 4'd6;
  localparam logic [3:0] HILO_MTLO  = 4'd7;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  // Signed divide on magnitudes so the 0x80000000 / -1 case needs no special path.
  // Returns {remainder, quotient}; a zero divisor is masked, the result is discarded anyway.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r, quo, rem;
    ua  = a[31] ? (32'd0 - a) : a;
    ub  = b[31] ? (32'd0 - b) : b;
    ub  = (ub == 32'd0) ? 32'd1 : ub;
    q   = ua / ub;
    r   = ua % ub;
    quo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
    rem = a[31] ? (32'd0 - r) : r;
    return {rem, quo};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bs;
    bs = (b == 32'd0) ? 32'd1 : b;
    return {a % bs, a / bs};
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    hir_q, hir_d, lor_q, lor_d;
  logic           dz_q, dz_d;
  logic [63:0]    smul_s, umul_s, sdiv_s, udiv_s;
  logic           is_md_s, accept_s;

  assign smul_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign umul_s  = {32'd0, A} * {32'd0, B};
  assign sdiv_s  = sdiv(A, B);
  assign udiv_s  = udiv(A, B);
  assign is_md_s = (HILOType[3:2] == 2'b00);
  assign accept_s = (Req == 1'b0) && (state_q == S_IDLE);

  assign Start = is_md_s && accept_s;
  assign Busy  = (state_q == S_BUSY);

  // Read path for mfhi/mflo; any other command reads as zero.
  always_comb begin
    HILO_out = 32'd0;
    case (HILOType)
      HILO_MFHI: HILO_out = hi_q;
      HILO_MFLO: HILO_out = lo_q;
      default:   HILO_out = 32'd0;
    endcase
  end

  // Next-state logic: command acceptance in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hir_d   = hir_q;
    lor_d   = lor_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (HILOType)
            HILO_MULT: begin
              {hir_d, lor_d} = smul_s;
              dz_d    = 1'b0;
              cnt_d   = MULT_LD;
              state_d = S_BUSY;
            end
            HILO_MULTU: begin
              {hir_d, lor_d} = umul_s;
              dz_d    = 1'b0;
              cnt_d   = MULT_LD;
              state_d = S_BUSY;
            end
            HILO_DIV: begin
              {hir_d, lor_d} = sdiv_s;
              dz_d    = (B == 32'd0);
              cnt_d   = DIV_LD;
              state_d = S_BUSY;
            end
            HILO_DIVU: begin
              {hir_d, lor_d} = udiv_s;
              dz_d    = (B == 32'd0);
              cnt_d   = DIV_LD;
              state_d = S_BUSY;
            end
            HILO_MTHI: hi_d = A;
            HILO_MTLO: lo_d = A;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          if (!dz_q) begin
            hi_d = hir_q;
            lo_d = lor_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hir_q   <= 32'd0;
      lor_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hir_q   <= hir_d;
      lor_q   <= lor_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus randomized commands
// checked against a behavioural model using plain 64-bit arithmetic.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic [3:0]  HILOType;
  logic [31:0] A, B;
  logic        Req;
  logic        Start, Busy;
  logic [31:0] HILO_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural HI/LO, cycles left busy, pending result.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;
  bit          m_dz;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .HILOType(HILOType), .A(A), .B(B), .Req(Req),
    .Start(Start), .Busy(Busy), .HILO_out(HILO_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
    m_rem = 0; m_dz = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, input logic req);
    longint          sa, sb, q, r, p;
    longint unsigned pu;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !m_dz) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (!req) begin
      case (cmd)
        4'd0: begin
          p = longint'($signed(a)) * longint'($signed(b));
          {m_phi, m_plo} = p; m_dz = 1'b0; m_rem = 5;
        end
        4'd1: begin
          pu = longint'({32'd0, a}) * longint'({32'd0, b});
          {m_phi, m_plo} = pu; m_dz = 1'b0; m_rem = 5;
        end
        4'd2: begin
          m_rem = 10;
          m_dz  = (b == 32'd0);
          if (!m_dz) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            m_plo = q[31:0]; m_phi = r[31:0];
          end
        end
        4'd3: begin
          m_rem = 10;
          m_dz  = (b == 32'd0);
          if (!m_dz) begin
            m_plo = a / b; m_phi = a % b;
          end
        end
        4'd6: m_hi = a;
        4'd7: m_lo = a;
        default: ;
      endcase
    end
  endfunction

  function automatic logic exp_start(input logic [3:0] cmd, input logic req);
    return (cmd <= 4'd3) && !req && (m_rem == 0);
  endfunction

  function automatic logic [31:0] exp_out(input logic [3:0] cmd);
    if (cmd == 4'd4) return m_hi;
    if (cmd == 4'd5) return m_lo;
    return 32'd0;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check Busy.
  task automatic step(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      input logic req);
    HILOType = cmd; A = a; B = b; Req = req;
    #1;
    chk("start", Start, exp_start(cmd, req));
    chk("hilo_out", HILO_out, exp_out(cmd));
    @(posedge clk);
    model_edge(cmd, a, b, req);
    #1;
    chk("busy", Busy, (m_rem > 0));
  endtask

  task automatic peek(input logic [3:0] cmd, input logic [31:0] exp, input string tag);
    HILOType = cmd; Req = 1'b0;
    #1;
    chk(tag, HILO_out, exp);
  endtask

  task automatic run_busy(input string tag, input int exp_n);
    int n = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      step(4'hF, 32'd0, 32'd0, 1'b0);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    HILOType = 4'd0; Req = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_start", Start, 1'b1);
    HILOType = 4'd4; #1;
    chk("rst_mfhi", HILO_out, 32'd0);
    HILOType = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rnd_cmd();
    int r = $urandom_range(0, 11);
    if (r <= 7) return 4'(r);
    if (r == 8) return 4'hF;
    return 4'($urandom_range(8, 14));
  endfunction

  initial begin
    reset = 1'b0; HILOType = 4'hF; A = 32'd0; B = 32'd0; Req = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Signed multiply -2 * 3.
    step(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_busy("mult_busy_len", 5);
    peek(4'd4, 32'hFFFF_FFFF, "mult_hi");
    peek(4'd5, 32'hFFFF_FFFA, "mult_lo");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Unsigned multiply of all-ones.
    step(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_busy("multu_busy_len", 5);
    peek(4'd4, 32'hFFFF_FFFE, "multu_hi");
    peek(4'd5, 32'h0000_0001, "multu_lo");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Signed divide -7 / 2.
    step(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_busy("div_busy_len", 10);
    peek(4'd5, 32'hFFFF_FFFD, "div_lo");
    peek(4'd4, 32'hFFFF_FFFF, "div_hi");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Divide overflow.
    step(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_busy("ovf_busy_len", 10);
    peek(4'd5, 32'h8000_0000, "ovf_lo");
    peek(4'd4, 32'h0000_0000, "ovf_hi");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Divide by zero leaves HI/LO untouched.
    do_reset();
    step(4'd6, 32'h0000_1234, 32'd0, 1'b0);
    peek(4'd4, 32'h0000_1234, "mthi_next");
    step(4'd3, 32'd5, 32'd0, 1'b0);
    run_busy("dz_busy_len", 10);
    peek(4'd4, 32'h0000_1234, "dz_hi");
    peek(4'd5, 32'h0000_0000, "dz_lo");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Flush: mt and start suppressed by Req.
    step(4'd7, 32'h55, 32'd0, 1'b1);
    peek(4'd5, 32'h0000_0000, "flush_mtlo");
    HILOType = 4'd0; Req = 1'b1; #1;
    chk("flush_start", Start, 1'b0);
    step(4'd0, 32'd2, 32'd3, 1'b1);
    chk("flush_busy", Busy, 1'b0);

    // Mult while busy is ignored.
    step(4'd0, 32'd2, 32'd3, 1'b0);
    step(4'd0, 32'd100, 32'd100, 1'b0);
    run_busy("ignored_busy_len", 4);
    peek(4'd5, 32'd6, "ignored_lo");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Reset in the third cycle of a divide.
    step(4'd2, 32'd100, 32'd7, 1'b0);
    step(4'hF, 32'd0, 32'd0, 1'b0);
    step(4'hF, 32'd0, 32'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", Busy, 1'b0);
    peek(4'd4, 32'd0, "midrst_hi");
    peek(4'd5, 32'd0, "midrst_lo");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) step(4'hF, 32'd0, 32'd0, 1'b0);
    peek(4'd5, 32'd0, "midrst_lo_after");
    peek(4'd4, 32'd0, "midrst_hi_after");
    step(4'hF, 32'd0, 32'd0, 1'b0);

    // Randomized commands against the model.
    for (int i = 0; i < 3000; i++) begin
      step(rnd_cmd(), rnd_op(), rnd_op(), ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers, sitting in the E stage of the pipelined MIPS core. It executes the `HILOType` commands produced by the instruction decoder: mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It models multi-cycle latency with a busy counter. It exposes `Start`/`Busy` so the hazard unit can stall any subsequent md/mf/mt instruction.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of mult/multu, in cycles (≥1).
- `DIV_CYCLES`, default 10: busy duration of div/divu, in cycles (≥1).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `HILOType`  in  4  command from the E-stage control. Encodings (`HILO_*` macros): mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, none=4'b1111. Any other value means none.
- `A`  in  32  rs operand (forwarded).
- `B`  in  32  rt operand (forwarded).
- `Req`  in  1  exception/interrupt request from M stage. When 1, the E-stage instruction is being flushed.
- `Start`  out  1  combinational. 1 when `HILOType` is mult/multu/div/divu and `Req`=0 and `Busy`=0.
- `Busy`  out  1  registered. 1 while a mult/div is in flight.
- `HILO_out`  out  32  combinational. HI if `HILOType`=mfhi, LO if mflo, otherwise 0.

## Operation
- State: `HI`[31:0], `LO`[31:0], counter `cnt`[3:0] (widen if a parameter exceeds 15), `Busy`, and a pending-result pair `hi_r`/`lo_r` computed at start.
- Accept rule: a command takes effect only when `Req`=0 and `Busy`=0. Otherwise it is ignored entirely, with no state change.
- mult: {hi_r,lo_r} = $signed(A)*$signed(B), full 64-bit result.
- multu: {hi_r,lo_r} = A*B, unsigned 64-bit result.
- div: lo_r = signed quotient, truncated toward zero. hi_r = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_r=0x80000000, hi_r=0.
- divu: unsigned quotient in lo_r, unsigned remainder in hi_r.
- Divide by zero (B=0, div or divu): the unit still goes busy for `DIV_CYCLES`. HI/LO are left unchanged at completion.
- mthi/mtlo: HI or LO ← A at the next edge. Not multi-cycle; `Busy` stays 0.
- mfhi/mflo: pure combinational read of the current HI/LO.
- `Req` rising while `Busy`=1 does not abort. The in-flight operation belongs to an older, committed instruction and completes normally.

State machine (IDLE/BUSY, encoded by `Busy`):
- IDLE → BUSY on an edge with `Start`=1. That edge loads `cnt` with MULT_CYCLES or DIV_CYCLES and latches hi_r/lo_r (and a div-by-zero flag).
- While in BUSY, each edge with `cnt`>1 decrements `cnt`.
- The edge with `cnt`=1 writes HI←hi_r and LO←lo_r (unless div-by-zero), clears `Busy` and `cnt`, and returns to IDLE.

## Timing
- Reset (`reset`=0, asynchronous): HI=0, LO=0, cnt=0, Busy=0, hi_r=lo_r=0, with immediate effect. A reset mid-operation discards the pending result.
  - Outputs during reset: `Start` follows its combinational rule with `Busy`=0. `HILO_out`=0 for mf commands and 0 otherwise.
- Start accepted at edge t:
  - `Busy`=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES), i.e. exactly N cycles.
  - New HI/LO are visible from cycle t+N+1, the same cycle in which `Busy` first reads 0.
- mthi/mtlo at edge t: new value is visible on `HILO_out` in cycle t+1.
- Hazard contract: the core stalls any md/mf/mt instruction in E while `Start`|`Busy`. The unit therefore never needs to handle an mf during `Busy`. If one is presented anyway, it returns the old HI/LO.
- Simultaneous events:
  - `Req`=1 together with mt: no write.
  - `Req`=1 together with a start: no start.
  - A completion edge coinciding with a new command: the command is ignored, because `Busy` was 1 in that cycle.

## Test plan
- Signed multiply: after reset, mult with A=0xFFFFFFFE (−2), B=3. `Busy` is high for exactly 5 cycles; afterwards mfhi=0xFFFFFFFF and mflo=0xFFFFFFFA.
- Unsigned multiply: multu with A=B=0xFFFFFFFF. After 5 cycles HI=0xFFFFFFFE and LO=0x00000001.
- Signed divide: div with A=−7 (0xFFFFFFF9), B=2. `Busy` is high for 10 cycles; then LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1).
- Divide overflow: div with A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000 and HI=0.
- Divide by zero: mthi 0x1234 then divu by 0. `Busy` is high for 10 cycles; HI stays 0x1234 and LO stays 0.
- Flush and mid-operation events:
  - mtlo 0x55 with `Req`=1 leaves LO=0, and mult with `Req`=1 gives `Start`=0, `Busy`=0.
  - A mult issued while `Busy` is ignored.
  - Asserting `reset` low at cycle 3 of a div clears `Busy`, HI and LO immediately, and no result appears afterwards.
